// File: rtl/coin_credit.sv
`default_nettype none
// ============================================================================
//  Module   : coin_credit
//  Purpose  : Payment stage in front of the wash-cycle controller. Latches the
//             selected wash mode, counts coin insertions against that mode's
//             price, and returns excess or cancelled credit as coin-return
//             pulses. Holds 'paid' until the controller reports cycle_done.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: PAY_TIMEOUT_EN
//    When defined, COLLECT refunds and aborts after TIMEOUT cycles without a
//    coin. When undefined, COLLECT waits indefinitely.
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system tick clock (190 Hz)
//    rst        in   asynchronous, active-high reset
//    coin       in   debounced coin level, one coin per rising edge
//    mode1..3   in   debounced mode select levels
//    cancel     in   user cancel level
//    cycle_done in   one-cycle pulse from controller at end of cycle
//    paid       out  payment complete (level)
//    mode_sel   out  latched mode: 0 = none, 1, 2, 3
//    credit     out  current credit
//    coin_rtrn  out  one-cycle pulse per returned coin
//    Error      out  one-cycle pulse on invalid (multiple) mode selection
// ============================================================================
module coin_credit #(
  parameter int unsigned PRICE1     = 2,
  parameter int unsigned PRICE2     = 3,
  parameter int unsigned PRICE3     = 4,
  parameter int unsigned CREDIT_MAX = 9,
  parameter int unsigned CW         = 4,
  parameter int unsigned TIMEOUT    = 1900,
  parameter int unsigned TW         = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin,
  input  logic          mode1,
  input  logic          mode2,
  input  logic          mode3,
  input  logic          cancel,
  input  logic          cycle_done,
  output logic          paid,
  output logic [1:0]    mode_sel,
  output logic [CW-1:0] credit,
  output logic          coin_rtrn,
  output logic          Error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PAID    = 2'd2,
    S_RETURN  = 2'd3
  } state_t;

  // Return count is one bit wider than credit so a full refund plus a few
  // rejected coins never overflows in practice; it saturates regardless.
  localparam int unsigned   RW           = CW + 1;
  localparam int unsigned   AW           = RW + 1;
  localparam int unsigned   SW           = AW + 1;
  localparam logic [RW-1:0] C_RET_MAX    = {RW{1'b1}};
  localparam logic [CW-1:0] C_PRICE1     = CW'(PRICE1);
  localparam logic [CW-1:0] C_PRICE2     = CW'(PRICE2);
  localparam logic [CW-1:0] C_PRICE3     = CW'(PRICE3);
  localparam logic [CW-1:0] C_CREDIT_MAX = CW'(CREDIT_MAX);

  // Reject parameter sets the datapath cannot represent.
  if ((CREDIT_MAX < PRICE1) || (CREDIT_MAX < PRICE2) || (CREDIT_MAX < PRICE3) ||
      (CREDIT_MAX >= (1 << CW)) || (TIMEOUT < 2) || (TIMEOUT > (1 << TW)))
  begin : g_cfg_check
    $error("coin_credit: illegal parameter combination");
  end

  // Registered state and outputs
  state_t        state_q, state_d;
  logic          coin_q;
  logic          multi_q;
  logic          paid_q, paid_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          rtrn_q;
  logic          err_q, err_d;
  logic [RW-1:0] ret_q, ret_d;

  // Combinational helpers
  logic          w_coin_edge;
  logic [1:0]    w_sel_cnt;
  logic          w_one_sel;
  logic          w_multi;
  logic [1:0]    w_sel_mode;
  logic [CW-1:0] w_price;
  logic          w_credit_full;
  logic [CW-1:0] w_credit_inc;
  logic          w_tmo_hit;
  logic          w_abort;
  logic          w_reach;
  logic          w_dec;
  logic [AW-1:0] w_ret_add;
  logic [SW-1:0] w_ret_sum;

  assign w_coin_edge = coin & ~coin_q;

  assign w_sel_cnt  = {1'b0, mode1} + {1'b0, mode2} + {1'b0, mode3};
  assign w_one_sel  = (w_sel_cnt == 2'd1);
  assign w_multi    = (w_sel_cnt >= 2'd2);
  assign w_sel_mode = mode1 ? 2'd1 : (mode2 ? 2'd2 : 2'd3);

  always_comb begin
    w_price = C_PRICE1;
    case (mode_q)
      2'd2:    w_price = C_PRICE2;
      2'd3:    w_price = C_PRICE3;
      default: w_price = C_PRICE1;
    endcase
  end

  // Credit after this cycle's coin; a coin at saturation is refunded instead.
  assign w_credit_full = (credit_q >= C_CREDIT_MAX);
  assign w_credit_inc  = (w_coin_edge && !w_credit_full) ? credit_q + CW'(1) : credit_q;

  assign w_abort = cancel | w_tmo_hit;
  assign w_reach = (w_credit_inc >= w_price);

  // Drain: pulse only when the previous cycle was a gap, giving 1-on/1-off.
  assign w_dec = (ret_q != '0) && !rtrn_q;

  // Coins to be added to the return count this cycle.
  always_comb begin
    w_ret_add = '0;
    case (state_q)
      S_COLLECT: begin
        w_ret_add = {{(AW-1){1'b0}}, w_coin_edge & w_credit_full};
        if (w_abort) begin
          w_ret_add = w_ret_add + AW'(w_credit_inc);
        end else if (w_reach) begin
          w_ret_add = w_ret_add + AW'(w_credit_inc - w_price);
        end
      end
      default: w_ret_add = {{(AW-1){1'b0}}, w_coin_edge};
    endcase
  end

  // w_dec implies ret_q >= 1, so the subtraction cannot underflow.
  assign w_ret_sum = SW'(ret_q) + SW'(w_ret_add) - SW'(w_dec);
  assign ret_d     = (w_ret_sum > SW'(C_RET_MAX)) ? C_RET_MAX : w_ret_sum[RW-1:0];

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    paid_d   = paid_q;
    mode_d   = mode_q;
    credit_d = credit_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_one_sel) begin
          mode_d  = w_sel_mode;
          state_d = S_COLLECT;
        end else if (w_multi && !multi_q) begin
          // One pulse per invalid selection, even if it is held.
          err_d = 1'b1;
        end
      end
      S_COLLECT: begin
        credit_d = w_credit_inc;
        if (w_abort) begin
          credit_d = '0;
          mode_d   = 2'd0;
          state_d  = S_RETURN;
        end else if (w_reach) begin
          credit_d = w_price;
          paid_d   = 1'b1;
          state_d  = S_PAID;
        end
      end
      S_PAID: begin
        if (cycle_done) begin
          credit_d = '0;
          mode_d   = 2'd0;
          paid_d   = 1'b0;
          state_d  = (ret_d != '0) ? S_RETURN : S_IDLE;
        end
      end
      S_RETURN: begin
        if (ret_d == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      coin_q   <= 1'b0;
      multi_q  <= 1'b0;
      paid_q   <= 1'b0;
      mode_q   <= 2'd0;
      credit_q <= '0;
      rtrn_q   <= 1'b0;
      err_q    <= 1'b0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      coin_q   <= coin;
      multi_q  <= w_multi;
      paid_q   <= paid_d;
      mode_q   <= mode_d;
      credit_q <= credit_d;
      rtrn_q   <= w_dec;
      err_q    <= err_d;
      ret_q    <= ret_d;
    end
  end

`ifdef PAY_TIMEOUT_EN
  // Idle-time counter for COLLECT; cleared by every coin and outside COLLECT.
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q;

  assign w_tmo_hit = (state_q == S_COLLECT) && !w_coin_edge && (tmo_q == C_TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if ((state_q == S_COLLECT) && (state_d == S_COLLECT) && !w_coin_edge) begin
      tmo_q <= tmo_q + TW'(1);
    end else begin
      tmo_q <= '0;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  assign paid      = paid_q;
  assign mode_sel  = mode_q;
  assign credit    = credit_q;
  assign coin_rtrn = rtrn_q;
  assign Error     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_credit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_coin_credit
//  Purpose  : Directed self-checking bench for coin_credit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_coin_credit;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          coin;
  logic          mode1;
  logic          mode2;
  logic          mode3;
  logic          cancel;
  logic          cycle_done;
  logic          paid;
  logic [1:0]    mode_sel;
  logic [CW-1:0] credit;
  logic          coin_rtrn;
  logic          Error;

  int   checks    = 0;
  int   errors    = 0;
  int   rtrn_cnt  = 0;
  int   b2b       = 0;
  int   paid_seen = 0;
  int   base      = 0;
  logic prev_rtrn = 1'b0;

  coin_credit #(
    .PRICE1    (2),
    .PRICE2    (3),
    .PRICE3    (4),
    .CREDIT_MAX(9),
    .CW        (CW),
    .TIMEOUT   (20),
    .TW        (11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coin      (coin),
    .mode1     (mode1),
    .mode2     (mode2),
    .mode3     (mode3),
    .cancel    (cancel),
    .cycle_done(cycle_done),
    .paid      (paid),
    .mode_sel  (mode_sel),
    .credit    (credit),
    .coin_rtrn (coin_rtrn),
    .Error     (Error)
  );

  always #5 clk = ~clk;

  // Pulse counter and spacing monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (coin_rtrn === 1'b1) rtrn_cnt = rtrn_cnt + 1;
    if (coin_rtrn === 1'b1 && prev_rtrn === 1'b1) b2b = b2b + 1;
    prev_rtrn = coin_rtrn;
    if (paid === 1'b1) paid_seen = 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic coin_pulse();
    coin = 1'b1;
    tick();
    coin = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; coin = 1'b0; mode1 = 1'b0; mode2 = 1'b0; mode3 = 1'b0;
    cancel = 1'b0; cycle_done = 1'b0;
    tick(2);

    // Reset state
    check("rst_paid",   32'(paid),      32'd0);
    check("rst_mode",   32'(mode_sel),  32'd0);
    check("rst_credit", 32'(credit),    32'd0);
    check("rst_rtrn",   32'(coin_rtrn), 32'd0);
    check("rst_error",  32'(Error),     32'd0);
    rst = 1'b0;
    tick(2);

    // Mode 2, exact payment of 3 coins
    base = rtrn_cnt;
    mode2 = 1'b1; tick(); mode2 = 1'b0;
    check("s1_mode", 32'(mode_sel), 32'd2);
    coin_pulse();
    coin_pulse();
    check("s1_credit2",  32'(credit), 32'd2);
    check("s1_notpaid",  32'(paid),   32'd0);
    coin = 1'b1; tick();
    check("s1_paid",     32'(paid),     32'd1);
    check("s1_credit",   32'(credit),   32'd3);
    check("s1_mode_hld", 32'(mode_sel), 32'd2);
    coin = 1'b0; tick(4);
    check("s1_paid_hld", 32'(paid), 32'd1);
    check("s1_no_rtrn",  32'(rtrn_cnt - base), 32'd0);
    cycle_done = 1'b1; tick(); cycle_done = 1'b0;
    check("s1_done_paid",   32'(paid),     32'd0);
    check("s1_done_credit", 32'(credit),   32'd0);
    check("s1_done_mode",   32'(mode_sel), 32'd0);
    tick(2);

    // Mode 1, one excess coin arriving after payment
    base = rtrn_cnt;
    mode1 = 1'b1; tick(); mode1 = 1'b0;
    check("s2_mode", 32'(mode_sel), 32'd1);
    coin_pulse();
    coin = 1'b1; tick();
    check("s2_paid",   32'(paid),   32'd1);
    check("s2_credit", 32'(credit), 32'd2);
    coin = 1'b0; tick();
    coin = 1'b1; tick();
    coin = 1'b0; tick();
    check("s2_first_rtrn", 32'(coin_rtrn), 32'd1);
    tick(5);
    check("s2_rtrn_cnt", 32'(rtrn_cnt - base), 32'd1);
    check("s2_credit_hld", 32'(credit), 32'd2);
    cycle_done = 1'b1; tick(); cycle_done = 1'b0;
    check("s2_done_paid", 32'(paid), 32'd0);
    tick(2);

    // Mode 3, 3 coins then cancel
    base = rtrn_cnt;
    b2b = 0;
    paid_seen = 0;
    mode3 = 1'b1; tick(); mode3 = 1'b0;
    check("s3_mode", 32'(mode_sel), 32'd3);
    coin_pulse();
    coin_pulse();
    coin_pulse();
    check("s3_credit", 32'(credit), 32'd3);
    cancel = 1'b1; tick(); cancel = 1'b0;
    check("s3_cancel_credit", 32'(credit),    32'd0);
    check("s3_cancel_mode",   32'(mode_sel),  32'd0);
    check("s3_cancel_rtrn0",  32'(coin_rtrn), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("s3_rtrn_seq%0d", i), 32'(coin_rtrn), 32'(i % 2));
    end
    tick(3);
    check("s3_rtrn_cnt",   32'(rtrn_cnt - base), 32'd3);
    check("s3_spacing",    32'(b2b),       32'd0);
    check("s3_never_paid", 32'(paid_seen), 32'd0);
    // Back in IDLE: a new selection must be accepted
    mode1 = 1'b1; tick(); mode1 = 1'b0;
    check("s3_idle_accept", 32'(mode_sel), 32'd1);
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick(2);
    check("s3_idle_mode", 32'(mode_sel), 32'd0);

    // Invalid selection and coin rejected in IDLE
    base = rtrn_cnt;
    mode1 = 1'b1; mode2 = 1'b1; tick(); mode1 = 1'b0; mode2 = 1'b0;
    check("s4_error",      32'(Error),    32'd1);
    check("s4_mode",       32'(mode_sel), 32'd0);
    tick();
    check("s4_error_once", 32'(Error),    32'd0);
    coin = 1'b1; tick(); coin = 1'b0;
    check("s4_mode_coin", 32'(mode_sel), 32'd0);
    tick();
    check("s4_rtrn_pulse", 32'(coin_rtrn), 32'd1);
    tick(4);
    check("s4_rtrn_cnt", 32'(rtrn_cnt - base), 32'd1);

    // Reset in COLLECT with credit 2 (mode 2, price 3)
    mode2 = 1'b1; tick(); mode2 = 1'b0;
    coin_pulse();
    coin_pulse();
    check("s5_credit_pre", 32'(credit), 32'd2);
    base = rtrn_cnt;
    rst = 1'b1;
    #1;
    check("s5_rst_credit", 32'(credit),   32'd0);
    check("s5_rst_mode",   32'(mode_sel), 32'd0);
    check("s5_rst_paid",   32'(paid),     32'd0);
    tick();
    rst = 1'b0;
    tick(6);
    check("s5_no_refund", 32'(rtrn_cnt - base), 32'd0);
    check("s5_credit",    32'(credit), 32'd0);

    // COLLECT with one coin and no further activity
    base = rtrn_cnt;
    mode1 = 1'b1; tick(); mode1 = 1'b0;
    coin_pulse();
    check("s6_credit", 32'(credit), 32'd1);
`ifdef PAY_TIMEOUT_EN
    tick(25);
    check("s6_tmo_rtrn",   32'(rtrn_cnt - base), 32'd1);
    check("s6_tmo_mode",   32'(mode_sel), 32'd0);
    check("s6_tmo_credit", 32'(credit),   32'd0);
`else
    tick(100);
    check("s6_wait_mode",   32'(mode_sel), 32'd1);
    check("s6_wait_credit", 32'(credit),   32'd1);
    check("s6_wait_rtrn",   32'(rtrn_cnt - base), 32'd0);
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick(4);
    check("s6_cancel_rtrn", 32'(rtrn_cnt - base), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
